// File: rtl/lc3b_ucode_pkg.sv
// Shared microword layout, COND encodings and sequencer constants
// for the LC-3b microcoded control unit.
package lc3b_ucode_pkg;

   localparam int CW_W  = 35;
   localparam int DP_W  = 26;
   localparam int ST_W  = 6;

   localparam int IRD_BIT    = 34;
   localparam int COND_HI    = 33;
   localparam int COND_LO    = 32;
   localparam int J_HI       = 31;
   localparam int J_LO       = 26;
   localparam int LD_BEN_BIT = 22;
   localparam int DP_HI      = 25;
   localparam int DP_LO      = 0;

   typedef enum logic [1:0] {
      COND_UNCOND = 2'b00,
      COND_READY  = 2'b01,
      COND_BEN    = 2'b10,
      COND_ADDR   = 2'b11
   } cond_e;

   localparam logic [ST_W-1:0] FETCH_STATE  = 6'd18;
   localparam logic [ST_W-1:0] DECODE_STATE = 6'd32;

endpackage

// File: rtl/lc3b_next_state_logic.sv
// Combinational next micro-address from IRD/COND/J, IR bits, BEN and R.
// Ports: ctrl_word_i, ir_hi_i, ben_i, mem_ready_i -> next_o, illegal_o.
module lc3b_next_state_logic
   import lc3b_ucode_pkg::*;
(
   input  logic [34:0] ctrl_word_i,
   input  logic [6:0]  ir_hi_i,
   input  logic        ben_i,
   input  logic        mem_ready_i,
   output logic [5:0]  next_o,
   output logic        illegal_o
);

   cond_e      cond;
   logic [5:0] j;

   assign cond      = cond_e'(ctrl_word_i[COND_HI:COND_LO]);
   assign j         = ctrl_word_i[J_HI:J_LO];
   // An all-zero microword marks an unused control-store slot.
   assign illegal_o = ~|ctrl_word_i;

   always_comb begin
      next_o = j;
      if (ctrl_word_i[IRD_BIT]) begin
         next_o = {2'b00, ir_hi_i[6:3]};
      end else begin
         unique case (cond)
            COND_UNCOND: next_o = j;
            COND_READY:  next_o = j | {4'b0, mem_ready_i, 1'b0};
            COND_BEN:    next_o = j | {3'b0, ben_i, 2'b0};
            COND_ADDR:   next_o = j | {5'b0, ir_hi_i[2]};
         endcase
      end
   end

endmodule

// File: rtl/lc3b_microsequencer.sv
// LC-3b microsequencer: micro-state register, BEN, memory watchdog, halt.
// Ports: clk, rst_n, ctrl_word, ir_hi, nzp, mem_ready, halt ->
//        state, dp_ctrl, ben, mem_timeout, illegal_state.
module lc3b_microsequencer #(
   parameter logic [5:0] FETCH_STATE = 6'd18,
   parameter int         MEM_TIMEOUT = 255,
   parameter int         CNT_W       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [34:0] ctrl_word,
   input  logic [6:0]  ir_hi,
   input  logic [2:0]  nzp,
   input  logic        mem_ready,
   input  logic        halt,
   output logic [5:0]  state,
   output logic [25:0] dp_ctrl,
   output logic        ben,
   output logic        mem_timeout,
   output logic        illegal_state
);
   import lc3b_ucode_pkg::*;

   logic [5:0]       state_q, state_d, ns;
   logic             ben_q, ben_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;
   logic             ill_q, ill_d;
   logic             ill_word;
   logic             wait_st;

   lc3b_next_state_logic u_nsl (
      .ctrl_word_i (ctrl_word),
      .ir_hi_i     (ir_hi),
      .ben_i       (ben_q),
      .mem_ready_i (mem_ready),
      .next_o      (ns),
      .illegal_o   (ill_word)
   );

   assign wait_st =
      (ctrl_word[COND_HI:COND_LO] == COND_READY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH_STATE;
         ben_q   <= 1'b0;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ben_q   <= ben_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         ill_q   <= ill_d;
      end
   end

   // Halt freezes everything except the sticky timeout flag; an
   // illegal word seen while halted is acted on only after release.
   always_comb begin
      state_d = state_q;
      ben_d   = ben_q;
      cnt_d   = cnt_q;
      ill_d   = 1'b0;
      tmo_d   = tmo_q | (cnt_q >= CNT_W'(MEM_TIMEOUT));
      if (!halt) begin
         if (ill_word) begin
            state_d = FETCH_STATE;
            ill_d   = 1'b1;
         end else begin
            state_d = ns;
         end
         if (ctrl_word[LD_BEN_BIT]) begin
            ben_d = |(ir_hi[2:0] & nzp);
         end
         if (mem_ready || (state_d != state_q)) begin
            cnt_d = '0;
         end else if (wait_st && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      dp_ctrl = halt ? '0 : ctrl_word[DP_HI:DP_LO];
   end

   assign state         = state_q;
   assign ben           = ben_q;
   assign mem_timeout   = tmo_q;
   assign illegal_state = ill_q;

endmodule
